// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, baud table, divisor function and FSM state types
package uart_pkg;

    localparam int DIV_W = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Baud rate table indexed by baud_select.
    function automatic int unsigned baud_rate(input int idx);
        case (idx)
            0:       return 300;
            1:       return 1200;
            2:       return 4800;
            3:       return 9600;
            4:       return 19200;
            5:       return 38400;
            6:       return 57600;
            default: return 115200;
        endcase
    endfunction

    // Rounded 16x oversampling divisor; never below 1 so the tick keeps running.
    function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_hz, input int idx);
        int unsigned baud;
        int unsigned dv;
        baud = baud_rate(idx);
        dv   = (clk_hz + 8 * baud) / (16 * baud);
        if (dv == 0) dv = 1;
        return dv[DIV_W-1:0];
    endfunction

endpackage

// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - 16x sample-tick generator shared by transmitter and receiver
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       tick
);

    // Divisors are elaboration-time constants; only a table lookup remains in hardware.
    localparam logic [DIV_W-1:0] DIV_TABLE [8] = '{
        baud_divisor(CLK_HZ, 0), baud_divisor(CLK_HZ, 1),
        baud_divisor(CLK_HZ, 2), baud_divisor(CLK_HZ, 3),
        baud_divisor(CLK_HZ, 4), baud_divisor(CLK_HZ, 5),
        baud_divisor(CLK_HZ, 6), baud_divisor(CLK_HZ, 7)
    };

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_last;
    logic [2:0]       sel_q;

    assign div_last = DIV_TABLE[baud_select] - DIV_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            sel_q <= '0;
            tick  <= 1'b0;
        end else if (baud_select != sel_q) begin
            sel_q <= baud_select;
            cnt   <= '0;
            tick  <= 1'b0;
        end else if (cnt == div_last) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - full-duplex UART transceiver; optional internal loopback under UART_LOOPBACK_EN
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int          DATA_W    = 8,
    parameter int          PARITY    = 1,
    parameter int          STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
`ifdef UART_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic [2:0]        baud_select,
    input  logic              Tx_EN,
    input  logic              Tx_WR,
    input  logic [DATA_W-1:0] Tx_DATA,
    output logic              Tx_BUSY,
    output logic              TxD,
    input  logic              RxD,
    input  logic              Rx_EN,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_PERROR,
    output logic              Rx_FERROR
);

    localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    logic tick;
    logic armed;
    logic rx_line;

    uart_baud_ctrl #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .tick        (tick)
    );

    // Holds off any action until the second edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    tx_state_t         tx_state, tx_state_n;
    logic [3:0]        tx_tick, tx_tick_n;
    logic [2:0]        tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic              tx_par, tx_par_n;
    logic              tx_wait, tx_wait_n;
    logic              tx_busy, tx_busy_n;
    logic              txd_r, txd_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_wait  <= 1'b0;
            tx_busy  <= 1'b0;
            txd_r    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_wait  <= tx_wait_n;
            tx_busy  <= tx_busy_n;
            txd_r    <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_tick_n  = tx_tick;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_wait_n  = tx_wait;
        tx_busy_n  = tx_busy;
        txd_n      = txd_r;
        if (!Tx_EN) begin
            tx_state_n = TX_IDLE;
            tx_tick_n  = '0;
            tx_bit_n   = '0;
            tx_wait_n  = 1'b0;
            tx_busy_n  = 1'b0;
            txd_n      = 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (Tx_WR && armed) begin
                        tx_shift_n = Tx_DATA;
                        tx_par_n   = (PARITY == PAR_ODD) ? ~(^Tx_DATA) : (^Tx_DATA);
                        tx_busy_n  = 1'b1;
                        tx_wait_n  = 1'b1;
                        tx_tick_n  = '0;
                        tx_state_n = TX_START;
                    end
                end
                TX_START: begin
                    // The start bit begins on the first tick after the latch.
                    if (tick) begin
                        if (tx_wait) begin
                            tx_wait_n = 1'b0;
                            txd_n     = 1'b0;
                        end else if (tx_tick == 4'd15) begin
                            tx_tick_n  = '0;
                            tx_bit_n   = '0;
                            txd_n      = tx_shift[0];
                            tx_state_n = TX_DATA;
                        end else begin
                            tx_tick_n = tx_tick + 4'd1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_tick == 4'd15) begin
                            tx_tick_n = '0;
                            if (tx_bit == BIT_LAST) begin
                                if (PARITY != PAR_NONE) begin
                                    txd_n      = tx_par;
                                    tx_state_n = TX_PARITY;
                                end else begin
                                    txd_n      = 1'b1;
                                    tx_bit_n   = '0;
                                    tx_state_n = TX_STOP;
                                end
                            end else begin
                                tx_bit_n   = tx_bit + 3'd1;
                                tx_shift_n = tx_shift >> 1;
                                txd_n      = tx_shift[1];
                            end
                        end else begin
                            tx_tick_n = tx_tick + 4'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        if (tx_tick == 4'd15) begin
                            tx_tick_n  = '0;
                            tx_bit_n   = '0;
                            txd_n      = 1'b1;
                            tx_state_n = TX_STOP;
                        end else begin
                            tx_tick_n = tx_tick + 4'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_tick == 4'd15) begin
                            tx_tick_n = '0;
                            if (tx_bit == STOP_LAST) begin
                                tx_bit_n   = '0;
                                tx_busy_n  = 1'b0;
                                tx_state_n = TX_IDLE;
                            end else begin
                                tx_bit_n = tx_bit + 3'd1;
                            end
                        end else begin
                            tx_tick_n = tx_tick + 4'd1;
                        end
                    end
                end
                default: tx_state_n = TX_IDLE;
            endcase
        end
    end

    assign Tx_BUSY = tx_busy;

`ifdef UART_LOOPBACK_EN
    assign rx_line = loopback ? txd_r : RxD;
    assign TxD     = loopback ? 1'b1 : txd_r;
`else
    assign rx_line = RxD;
    assign TxD     = txd_r;
`endif

    logic rx_s1, rx_s2, rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_line;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    rx_state_t         rx_state, rx_state_n;
    logic [3:0]        rx_tick, rx_tick_n;
    logic [2:0]        rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic [DATA_W-1:0] rx_data, rx_data_n;
    logic              rx_par, rx_par_n;
    logic              rx_ferr, rx_ferr_n;
    logic              valid_n, perror_n, ferror_n;
    logic              par_bad;

    assign par_bad = (PARITY != PAR_NONE) && (((^rx_shift) ^ rx_par) != (PARITY == PAR_ODD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state  <= RX_IDLE;
            rx_tick   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_par    <= 1'b0;
            rx_ferr   <= 1'b0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            rx_tick   <= rx_tick_n;
            rx_bit    <= rx_bit_n;
            rx_shift  <= rx_shift_n;
            rx_data   <= rx_data_n;
            rx_par    <= rx_par_n;
            rx_ferr   <= rx_ferr_n;
            Rx_VALID  <= valid_n;
            Rx_PERROR <= perror_n;
            Rx_FERROR <= ferror_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        rx_par_n   = rx_par;
        rx_ferr_n  = rx_ferr;
        valid_n    = 1'b0;
        perror_n   = 1'b0;
        ferror_n   = 1'b0;
        if (!Rx_EN) begin
            rx_state_n = RX_IDLE;
            rx_tick_n  = '0;
            rx_bit_n   = '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall && armed) begin
                        rx_tick_n  = '0;
                        rx_state_n = RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start re-check rejects short glitches on the line.
                    if (tick) begin
                        if (rx_tick == 4'd7) begin
                            rx_tick_n = '0;
                            rx_bit_n  = '0;
                            rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick_n = rx_tick + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_tick == 4'd15) begin
                            rx_tick_n  = '0;
                            rx_shift_n = {rx_s2, rx_shift[DATA_W-1:1]};
                            if (rx_bit == BIT_LAST) begin
                                rx_bit_n   = '0;
                                rx_ferr_n  = 1'b0;
                                rx_state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                            end else begin
                                rx_bit_n = rx_bit + 3'd1;
                            end
                        end else begin
                            rx_tick_n = rx_tick + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (tick) begin
                        if (rx_tick == 4'd15) begin
                            rx_tick_n  = '0;
                            rx_par_n   = rx_s2;
                            rx_bit_n   = '0;
                            rx_ferr_n  = 1'b0;
                            rx_state_n = RX_STOP;
                        end else begin
                            rx_tick_n = rx_tick + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_tick == 4'd15) begin
                            rx_tick_n = '0;
                            if (rx_bit == STOP_LAST) begin
                                rx_data_n  = rx_shift;
                                rx_bit_n   = '0;
                                rx_state_n = RX_IDLE;
                                if (rx_ferr || !rx_s2) ferror_n = 1'b1;
                                else if (par_bad)      perror_n = 1'b1;
                                else                   valid_n  = 1'b1;
                            end else begin
                                rx_bit_n  = rx_bit + 3'd1;
                                rx_ferr_n = rx_ferr | ~rx_s2;
                            end
                        end else begin
                            rx_tick_n = rx_tick + 4'd1;
                        end
                    end
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

    assign Rx_DATA = rx_data;

endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - directed self-checking bench for uart_xcvr (default and 7O2 instances)
module tb_uart_xcvr;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] baud_select = 3'd7;
    logic       Tx_EN = 1'b0;
    logic       Tx_WR = 1'b0;
    logic [7:0] Tx_DATA = 8'h00;
    logic       Tx_BUSY, TxD;
    logic       rxd_drv = 1'b1;
    logic       tb_loop = 1'b0;
    logic       dut_rxd;
    logic       Rx_EN = 1'b0;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

    logic       Tx_WR1 = 1'b0;
    logic [6:0] Tx_DATA1 = 7'h00;
    logic       Tx_BUSY1, TxD1;
    logic [6:0] Rx_DATA1;
    logic       Rx_VALID1, Rx_PERROR1, Rx_FERROR1;
`ifdef UART_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_bad = 0;
    int n1_valid = 0, n1_err = 0;
    logic prev_any = 1'b0;

    assign dut_rxd = tb_loop ? TxD : rxd_drv;

    always #10 clk = ~clk;

    uart_xcvr dut (
        .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
        .loopback(loopback),
`endif
        .baud_select(baud_select), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
        .Tx_BUSY(Tx_BUSY), .TxD(TxD), .RxD(dut_rxd), .Rx_EN(Rx_EN), .Rx_DATA(Rx_DATA),
        .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
    );

    uart_xcvr #(.DATA_W(7), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset),
`ifdef UART_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .baud_select(baud_select), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR1), .Tx_DATA(Tx_DATA1),
        .Tx_BUSY(Tx_BUSY1), .TxD(TxD1), .RxD(TxD1), .Rx_EN(Rx_EN), .Rx_DATA(Rx_DATA1),
        .Rx_VALID(Rx_VALID1), .Rx_PERROR(Rx_PERROR1), .Rx_FERROR(Rx_FERROR1)
    );

    // Strobe monitor: counts each strobe, and flags overlapping or multi-cycle strobes.
    always @(negedge clk) begin
        if (Rx_VALID)  n_valid++;
        if (Rx_PERROR) n_perr++;
        if (Rx_FERROR) n_ferr++;
        if ((int'(Rx_VALID) + int'(Rx_PERROR) + int'(Rx_FERROR)) > 1) n_bad++;
        if (prev_any && (Rx_VALID || Rx_PERROR || Rx_FERROR)) n_bad++;
        prev_any = Rx_VALID | Rx_PERROR | Rx_FERROR;
        if (Rx_VALID1) n1_valid++;
        if (Rx_PERROR1 || Rx_FERROR1) n1_err++;
    end

    task automatic write_tx(input logic [7:0] d);
        @(negedge clk);
        Tx_DATA = d;
        Tx_WR   = 1'b1;
        @(negedge clk);
        Tx_WR   = 1'b0;
    endtask

    task automatic capture_tx(output logic [10:0] bits);
        int n = 0;
        bits = '1;
        while (TxD !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (TxD === 1'b0) begin
            repeat (216) @(negedge clk);
            for (int i = 0; i < 11; i++) begin
                bits[i] = TxD;
                if (i < 10) repeat (432) @(negedge clk);
            end
        end
    endtask

    task automatic measure_low(output int len);
        int n = 0;
        len = -1;
        while (TxD !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (TxD === 1'b0) begin
            len = 0;
            while (TxD === 1'b0 && len < 3000) begin
                len++;
                @(negedge clk);
            end
        end
    endtask

    task automatic send_rx(input logic [10:0] bits);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rxd_drv = bits[i];
            repeat (431) @(negedge clk);
        end
        @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if (TxD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", TxD); end
        n_checks++;
        if (Tx_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Tx_BUSY); end
        n_checks++;
        if (Rx_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_rxdata: got %h want 00", Rx_DATA); end
        n_checks++;
        if ({Rx_VALID, Rx_PERROR, Rx_FERROR} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000", {Rx_VALID, Rx_PERROR, Rx_FERROR});
        end
        #3 reset = 1'b1;
        Tx_EN = 1'b1;
        Rx_EN = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Start-bit length checks the divisor; then Tx_EN drop aborts the frame mid data.
    task automatic test_divisor_abort(input logic [2:0] sel, input int want_len, input int wait_bit2);
        int len;
        tb_loop = 1'b0;
        @(negedge clk);
        baud_select = sel;
        repeat (4) @(negedge clk);
        write_tx(8'h01);
        measure_low(len);
        n_checks++;
        if (len != want_len) begin n_fail++; $display("FAIL start_bit_len sel=%0d: got %0d want %0d", sel, len, want_len); end
        repeat (wait_bit2) @(negedge clk);
        n_checks++;
        if (TxD !== 1'b0) begin n_fail++; $display("FAIL data_bit2 sel=%0d: got %b want 0", sel, TxD); end
        Tx_EN = 1'b0;
        @(negedge clk);
        n_checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL abort sel=%0d: txd=%b busy=%b want 1 0", sel, TxD, Tx_BUSY);
        end
        Tx_EN = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_loop_a5;
        logic [10:0] bits;
        int v0, p0, f0, b0;
        baud_select = 3'd7;
        repeat (4) @(negedge clk);
        tb_loop = 1'b1;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr; b0 = n_bad;
        write_tx(8'hA5);
        capture_tx(bits);
        n_checks++;
        if (bits !== {1'b1, 1'b0, 8'hA5, 1'b0}) begin
            n_fail++; $display("FAIL a5_frame: got %b want %b", bits, {1'b1, 1'b0, 8'hA5, 1'b0});
        end
        repeat (300) @(negedge clk);
        n_checks++;
        if (Tx_BUSY !== 1'b0) begin n_fail++; $display("FAIL a5_busy_end: got %b want 0", Tx_BUSY); end
        n_checks++;
        if (n_valid - v0 != 1 || n_perr != p0 || n_ferr != f0 || n_bad != b0) begin
            n_fail++; $display("FAIL a5_strobes: valid=%0d perr=%0d ferr=%0d bad=%0d want 1 0 0 0",
                               n_valid - v0, n_perr - p0, n_ferr - f0, n_bad - b0);
        end
        n_checks++;
        if (Rx_DATA !== 8'hA5) begin n_fail++; $display("FAIL a5_rxdata: got %h want a5", Rx_DATA); end
    endtask

    task automatic test_rx_errors;
        int v0, p0, f0;
        tb_loop = 1'b0;
        rxd_drv = 1'b1;
        repeat (50) @(negedge clk);
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_rx({1'b1, 1'b1, 8'h3C, 1'b0});
        repeat (50) @(negedge clk);
        n_checks++;
        if (n_perr - p0 != 1 || n_valid != v0 || n_ferr != f0) begin
            n_fail++; $display("FAIL perr_strobes: valid=%0d perr=%0d ferr=%0d want 0 1 0",
                               n_valid - v0, n_perr - p0, n_ferr - f0);
        end
        n_checks++;
        if (Rx_DATA !== 8'h3C) begin n_fail++; $display("FAIL perr_rxdata: got %h want 3c", Rx_DATA); end
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_rx({1'b0, 1'b1, 8'h3C, 1'b0});
        repeat (50) @(negedge clk);
        n_checks++;
        if (n_ferr - f0 != 1 || n_valid != v0 || n_perr != p0) begin
            n_fail++; $display("FAIL ferr_strobes: valid=%0d perr=%0d ferr=%0d want 0 0 1",
                               n_valid - v0, n_perr - p0, n_ferr - f0);
        end
        n_checks++;
        if (Rx_DATA !== 8'h3C) begin n_fail++; $display("FAIL ferr_rxdata: got %h want 3c", Rx_DATA); end
    endtask

    task automatic test_glitch;
        int s0;
        s0 = n_valid + n_perr + n_ferr;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (81) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (1000) @(negedge clk);
        n_checks++;
        if (n_valid + n_perr + n_ferr != s0) begin
            n_fail++; $display("FAIL glitch_strobe: got %0d strobes want 0", n_valid + n_perr + n_ferr - s0);
        end
        n_checks++;
        if (Rx_DATA !== 8'h3C) begin n_fail++; $display("FAIL rxdata_hold: got %h want 3c", Rx_DATA); end
    endtask

    task automatic test_busy_write;
        logic [10:0] bits;
        int v0;
        tb_loop = 1'b1;
        v0 = n_valid;
        write_tx(8'h5A);
        fork
            capture_tx(bits);
            begin
                repeat (1000) @(negedge clk);
                n_checks++;
                if (Tx_BUSY !== 1'b1) begin n_fail++; $display("FAIL busy_mid: got %b want 1", Tx_BUSY); end
                Tx_DATA = 8'hFF;
                Tx_WR   = 1'b1;
                @(negedge clk);
                Tx_WR   = 1'b0;
            end
        join
        n_checks++;
        if (bits !== {1'b1, 1'b0, 8'h5A, 1'b0}) begin
            n_fail++; $display("FAIL busy_write_frame: got %b want %b", bits, {1'b1, 1'b0, 8'h5A, 1'b0});
        end
        repeat (300) @(negedge clk);
        n_checks++;
        if (n_valid - v0 != 1 || Rx_DATA !== 8'h5A || Tx_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL busy_write_rx: valid=%0d data=%h busy=%b want 1 5a 0",
                               n_valid - v0, Rx_DATA, Tx_BUSY);
        end
    endtask

    task automatic test_reset_mid;
        logic [10:0] bits;
        int v0;
        tb_loop = 1'b1;
        write_tx(8'h00);
        repeat (2000) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: txd=%b busy=%b want 1 0", TxD, Tx_BUSY);
        end
        @(negedge clk);
        #3 reset = 1'b1;
        v0 = n_valid;
        write_tx(8'hC3);
        capture_tx(bits);
        n_checks++;
        if (bits !== {1'b1, 1'b0, 8'hC3, 1'b0}) begin
            n_fail++; $display("FAIL post_reset_frame: got %b want %b", bits, {1'b1, 1'b0, 8'hC3, 1'b0});
        end
        repeat (300) @(negedge clk);
        n_checks++;
        if (n_valid - v0 != 1 || Rx_DATA !== 8'hC3) begin
            n_fail++; $display("FAIL post_reset_rx: valid=%0d data=%h want 1 c3", n_valid - v0, Rx_DATA);
        end
    endtask

    // 7 data bits, odd parity, 2 stops: 11 bit periods of 432 clocks plus up to one divisor of latch wait.
    task automatic test_variant;
        int v0, e0, cnt;
        v0 = n1_valid; e0 = n1_err;
        @(negedge clk);
        Tx_DATA1 = 7'h55;
        Tx_WR1   = 1'b1;
        @(negedge clk);
        Tx_WR1   = 1'b0;
        cnt = 0;
        while (Tx_BUSY1 === 1'b1 && cnt < 6000) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt < 4753 || cnt > 4780) begin
            n_fail++; $display("FAIL variant_busy_len: got %0d want 4753..4780", cnt);
        end
        repeat (50) @(negedge clk);
        n_checks++;
        if (n1_valid - v0 != 1 || n1_err != e0 || Rx_DATA1 !== 7'h55) begin
            n_fail++; $display("FAIL variant_rx: valid=%0d err=%0d data=%h want 1 0 55",
                               n1_valid - v0, n1_err - e0, Rx_DATA1);
        end
    endtask

`ifdef UART_LOOPBACK_EN
    task automatic test_loopback;
        int v0, lows;
        tb_loop  = 1'b0;
        rxd_drv  = 1'b1;
        loopback = 1'b1;
        v0 = n_valid;
        lows = 0;
        write_tx(8'h81);
        repeat (5200) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) begin n_fail++; $display("FAIL loopback_pin: got %0d low cycles want 0", lows); end
        n_checks++;
        if (n_valid - v0 != 1 || Rx_DATA !== 8'h81) begin
            n_fail++; $display("FAIL loopback_rx: valid=%0d data=%h want 1 81", n_valid - v0, Rx_DATA);
        end
        loopback = 1'b0;
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divisor_abort(3'd7, 432, 1000);
        test_divisor_abort(3'd6, 864, 2000);
        test_loop_a5();
        test_rx_errors();
        test_glitch();
        test_busy_write();
        test_reset_mid();
        test_variant();
`ifdef UART_LOOPBACK_EN
        test_loopback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter DATA_W, default 8, data bits per frame; legal range 5..8.
REQ-003 Parameter PARITY, default 1, parity mode: 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- baud_select  in  3  baud rate index.
- Tx_EN  in  1  transmitter enable.
- Tx_WR  in  1  write strobe.
- Tx_DATA  in  DATA_W  word to transmit.
- Tx_BUSY  out  1  frame in progress.
- TxD  out  1  serial output line.
- RxD  in  1  serial input line.
- Rx_EN  in  1  receiver enable.
- Rx_DATA  out  DATA_W  last received word.
- Rx_VALID  out  1  good-frame strobe.
- Rx_PERROR  out  1  parity error strobe.
- Rx_FERROR  out  1  framing error strobe.

Function
REQ-006 baud_select 0..7 SHALL map to 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
REQ-007 The 16x sample-tick divisor SHALL be round(CLK_HZ/(16*baud)); one tick is a single-cycle pulse.
REQ-008 The divisor counter SHALL restart whenever baud_select changes.
REQ-009 The frame SHALL be: start bit 0, then DATA_W data bits LSB first, then a parity bit if PARITY != 0, then STOP_BITS stop bits of 1; each bit lasts 16 ticks.
REQ-010 Transmitter states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY == 0.
REQ-011 When Tx_EN = 1 and Tx_BUSY = 0, Tx_WR = 1 SHALL latch Tx_DATA and raise Tx_BUSY on the next clock edge.
REQ-012 TxD SHALL go low at the next sample tick after the latch.
REQ-013 Tx_WR SHALL be ignored while Tx_BUSY = 1 or Tx_EN = 0.
REQ-014 Tx_BUSY SHALL fall one cycle after the last stop bit completes; TxD SHALL idle at 1.
REQ-015 Deasserting Tx_EN mid-frame SHALL abort the frame: TxD returns to 1, Tx_BUSY clears, state returns to IDLE.
REQ-016 RxD SHALL pass through a two-flop synchroniser before any use.
REQ-017 Receiver states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with Rx_EN = 1, a 1->0 transition on synchronised RxD SHALL start a frame.
REQ-019 The start bit SHALL be re-sampled at tick 8; if RxD is 1 there, the receiver returns to IDLE with no strobe (glitch rejection).
REQ-020 Data, parity and stop bits SHALL each be sampled at tick 8 of their bit.
REQ-021 At the final stop-bit sample, the receiver SHALL load Rx_DATA and assert exactly one of Rx_VALID, Rx_PERROR or Rx_FERROR for one cycle.
REQ-022 Framing error (any stop bit sampled as 0) SHALL take priority over parity error.
REQ-023 On Rx_PERROR or Rx_FERROR, Rx_DATA SHALL still be updated.
REQ-024 Rx_DATA SHALL hold its value until the next frame completes.
REQ-025 Deasserting Rx_EN mid-frame SHALL abort reception to IDLE with no strobe.
REQ-026 The transmitter and receiver SHALL operate concurrently and independently.

Reset
REQ-027 reset = 0 SHALL asynchronously force: both state machines to IDLE, all counters to 0, TxD = 1, Tx_BUSY = 0, Rx_DATA = 0, all strobes = 0, synchroniser flops = 1.
REQ-028 After reset is released, the first action SHALL occur no earlier than the second clock edge.

Configuration
REQ-029 With macro UART_LOOPBACK_EN defined, a 1-bit input port loopback SHALL exist; loopback = 1 routes internal TxD to the receiver input in place of RxD and holds the external TxD pin at 1.
REQ-030 Without UART_LOOPBACK_EN, the loopback port SHALL be absent and the receiver SHALL always use RxD.

Structure
REQ-031 A shared package uart_pkg SHALL hold:
- the baud rate table;
- the divisor computation function;
- parity mode constants;
- the tx and rx state enumerations.
REQ-032 The divisor and tick generator SHALL be a sub-module uart_baud_ctrl, instantiated once and shared by transmitter and receiver.

Verification
REQ-033 Throughput: CLK_HZ = 50e6, baud_select = 7 -> divisor 27 and bit period 432 clocks; TxD wired to RxD, write 0xA5 with even parity -> Rx_DATA = 0xA5, Rx_VALID pulse, no error strobes.
REQ-034 Parity and stop variants: DATA_W = 7, PARITY = 2, STOP_BITS = 2, write 0x55 -> Tx_BUSY high for 11 bit periods and Rx_VALID with Rx_DATA = 0x55.
REQ-035 Error priority: drive RxD with 0x3C whose parity bit is flipped -> Rx_PERROR only; also force the stop bit to 0 -> Rx_FERROR only.
REQ-036 Glitch and busy write: a 3-tick low pulse on idle RxD -> no strobe; Tx_WR while Tx_BUSY = 1 -> ignored and the frame is unchanged.
REQ-037 Reset mid-operation: assert reset in the middle of a TX frame -> TxD = 1 and Tx_BUSY = 0 asynchronously; a new write after release transmits correctly.
REQ-038 Loopback: with UART_LOOPBACK_EN defined, loopback = 1, write 0x81 -> Rx_VALID with 0x81 while the external TxD stays at 1.
